ball_ctl: RTL and testbench
===========================

Name: ball_ctl

Overview:
Per-frame motion controller for the Arkanoid ball. It generates the x_pos/y_pos centre coordinates consumed by the ball renderer in the VGA pixel pipeline. Positions update once per frame, at the start of vertical blanking, so they never change mid-frame. The block handles launch from the paddle, wall, paddle and brick bounces, and ball loss.

Parameters:
SCREEN_W, 800, visible width in pixels
SCREEN_H, 600, visible height in pixels
RADIUS, 10, ball radius in pixels
SPEED, 4, pixels moved per frame on each axis
PADDLE_Y, 560, y coordinate of the paddle top surface
PADDLE_W, 100, paddle width; paddle_x is the paddle centre
LOST_FRAMES, 60, frames held in LOST before returning to STICK

Ports:
pclk  in  1  pixel clock; the block's only clock
reset  in  1  synchronous, active-high reset
vblnk_in  in  1  vertical blank from the timing chain; its rising edge is the frame tick
launch  in  1  launch button, already synchronised to pclk
paddle_x  in  12  paddle centre x coordinate
brick_hit  in  1  one-or-more-cycle pulse from brick logic; reverses vertical direction
x_pos  out  12  ball centre x
y_pos  out  12  ball centre y
ball_lost  out  1  one-cycle pulse on entry to LOST
state  out  2  STICK=0, MOVE=1, LOST=2

Behaviour:
- One clock (pclk). Reset is synchronous and active-high. Reset has priority over all other activity.
- Reset values:
  - x_pos=SCREEN_W/2, y_pos=PADDLE_Y-RADIUS-1
  - state=STICK, ball_lost=0
  - dir_x=right, dir_y=up
  - vblnk_prev=0, launch_req=0, brick_req=0, lost_cnt=0
- Frame tick: tick = vblnk_in & ~vblnk_prev, where vblnk_prev is a registered copy of vblnk_in. All position and state updates occur only on tick cycles. Registered outputs show the new value one cycle after the tick. Outside ticks, every output holds (ball_lost=0).
- launch_req: set on any cycle with launch=1 while in STICK; cleared on the tick that consumes it.
- brick_req: set on any cycle with brick_hit=1 while in MOVE; cleared at the next tick. Multiple pulses within one frame count as one reversal.
- All arithmetic uses 13-bit signed intermediates, so left and top checks cannot underflow.
- STICK, on tick:
  - x_pos = paddle_x clamped to [RADIUS, SCREEN_W-1-RADIUS]; y_pos = PADDLE_Y-RADIUS-1.
  - If launch_req: go to MOVE with dir_x=right, dir_y=up. The first motion step happens on the following tick.
- MOVE, on tick, evaluated in this order:
  1. If brick_req, invert dir_y.
  2. Step nx = x ± SPEED, ny = y ± SPEED according to direction.
  3. Left wall: nx<=RADIUS → x=RADIUS, dir_x=right.
  4. Right wall: nx>=SCREEN_W-1-RADIUS → x=SCREEN_W-1-RADIUS, dir_x=left.
  5. Top wall: ny<=RADIUS → y=RADIUS, dir_y=down.
  6. Paddle: dir_y=down, y<PADDLE_Y-RADIUS, ny>=PADDLE_Y-RADIUS and |nx-paddle_x|<=PADDLE_W/2 → y=PADDLE_Y-RADIUS, dir_y=up. The edge case |dx|=PADDLE_W/2 counts as a hit.
  7. Bottom: ny>=SCREEN_H-1-RADIUS → y=SCREEN_H-1-RADIUS, go to LOST, ball_lost=1 for exactly one cycle, lost_cnt=0.
  8. Otherwise x=nx, y=ny.
  - The x and y axes resolve independently, so a corner hit reverses both directions.
- LOST: x_pos/y_pos hold. lost_cnt increments per tick. On the tick where lost_cnt==LOST_FRAMES-1, go to STICK and reposition the ball as in STICK on that same tick. launch is ignored in LOST.
- Reset asserted mid-MOVE or mid-LOST restores all reset values on the next edge. Any pending launch_req/brick_req is discarded.

Test Plan:
1. Reset, paddle_x=300, one vblnk rising edge → x_pos=300, y_pos=549, state=0. With paddle_x=5, next tick → x_pos=10 (clamped).
2. In STICK with x=300: launch pulse mid-frame, tick → state=1, x=300. Next tick → x=304, y=545. A tick without prior launch stays in STICK.
3. MOVE right with x=786, tick → x=789 and dir left; next tick → x=785. Top wall: y=13 going up, tick → y=10, then y=14.
4. Down at y=546, paddle_x=x+4+50, tick → y=550, dir up. Repeat with paddle_x=x+4+51 → ball continues down to y=589, ball_lost high one cycle, state=2. After 60 further ticks → state=0 and ball on the paddle.
5. Going up at y=300: brick_hit pulsed 3 times within one frame, tick → y=304 (single reversal). brick_hit in STICK has no effect.
6. Reset asserted during MOVE at x=500, y=200 → next cycle x=400, y=549, state=0, ball_lost=0.

Source files
------------

// File: rtl/ball_ctl.sv
// Per-frame ball motion controller: launch from the paddle, wall/paddle/brick bounces and ball loss.
// Position and state change only on the rising edge of vertical blank, so the renderer never sees a mid-frame move.
module ball_ctl #(
    parameter int SCREEN_W    = 800,
    parameter int SCREEN_H    = 600,
    parameter int RADIUS      = 10,
    parameter int SPEED       = 4,
    parameter int PADDLE_Y    = 560,
    parameter int PADDLE_W    = 100,
    parameter int LOST_FRAMES = 60
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        vblnk_in,
    input  logic        launch,
    input  logic [11:0] paddle_x,
    input  logic        brick_hit,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic        ball_lost,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_STICK = 2'd0,
        ST_MOVE  = 2'd1,
        ST_LOST  = 2'd2
    } state_e;

    localparam int CNT_W = (LOST_FRAMES > 1) ? $clog2(LOST_FRAMES) : 1;

    localparam logic signed [12:0] X_LO  = 13'(RADIUS);
    localparam logic signed [12:0] X_HI  = 13'(SCREEN_W - 1 - RADIUS);
    localparam logic signed [12:0] Y_LO  = 13'(RADIUS);
    localparam logic signed [12:0] Y_BOT = 13'(SCREEN_H - 1 - RADIUS);
    localparam logic signed [12:0] Y_PAD = 13'(PADDLE_Y - RADIUS);
    localparam logic signed [12:0] STEP  = 13'(SPEED);
    localparam logic signed [13:0] HALF_W = 14'(PADDLE_W / 2);
    localparam logic [11:0] X_RESET = 12'(SCREEN_W / 2);
    localparam logic [11:0] Y_REST  = 12'(PADDLE_Y - RADIUS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOST_FRAMES - 1);

    state_e            state_q, state_d;
    logic [11:0]       x_q, x_d;
    logic [11:0]       y_q, y_d;
    logic              dir_right_q, dir_right_d;
    logic              dir_up_q, dir_up_d;
    logic              vblnk_prev_q;
    logic              launch_req_q, launch_req_d;
    logic              brick_req_q, brick_req_d;
    logic              ball_lost_q, ball_lost_d;
    logic [CNT_W-1:0]  lost_cnt_q, lost_cnt_d;

    logic              tick;
    logic              up_eff;
    logic signed [12:0] cur_x, cur_y, pad_x, nx, ny;
    logic signed [13:0] dx, adx;
    logic              on_paddle;
    logic [11:0]       stick_x;

    assign tick   = vblnk_in & ~vblnk_prev_q;
    assign cur_x  = signed'({1'b0, x_q});
    assign cur_y  = signed'({1'b0, y_q});
    assign pad_x  = signed'({1'b0, paddle_x});

    // A pending brick hit flips the vertical direction before this frame's step.
    assign up_eff = dir_up_q ^ brick_req_q;
    assign nx     = dir_right_q ? cur_x + STEP : cur_x - STEP;
    assign ny     = up_eff ? cur_y - STEP : cur_y + STEP;

    // One extra bit: a far-right paddle against a ball near x=0 would overflow 13 bits.
    assign dx        = 14'(nx) - 14'(pad_x);
    assign adx       = dx[13] ? -dx : dx;
    assign on_paddle = (adx <= HALF_W);

    assign stick_x = (pad_x < X_LO) ? X_LO[11:0] :
                     (pad_x > X_HI) ? X_HI[11:0] : paddle_x;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        dir_right_d  = dir_right_q;
        dir_up_d     = dir_up_q;
        launch_req_d = launch_req_q;
        brick_req_d  = brick_req_q;
        lost_cnt_d   = lost_cnt_q;
        ball_lost_d  = 1'b0;

        if (state_q == ST_STICK && launch) launch_req_d = 1'b1;
        if (state_q == ST_MOVE && brick_hit) brick_req_d = 1'b1;

        if (tick) begin
            brick_req_d = 1'b0;
            case (state_q)
                ST_STICK: begin
                    x_d = stick_x;
                    y_d = Y_REST;
                    if (launch_req_q) begin
                        state_d      = ST_MOVE;
                        dir_right_d  = 1'b1;
                        dir_up_d     = 1'b1;
                        launch_req_d = 1'b0;
                    end
                end
                ST_MOVE: begin
                    // Horizontal axis resolves on its own, so corners reverse both directions.
                    if (nx <= X_LO) begin
                        x_d         = X_LO[11:0];
                        dir_right_d = 1'b1;
                    end else if (nx >= X_HI) begin
                        x_d         = X_HI[11:0];
                        dir_right_d = 1'b0;
                    end else begin
                        x_d = nx[11:0];
                    end

                    dir_up_d = up_eff;
                    if (ny <= Y_LO) begin
                        y_d      = Y_LO[11:0];
                        dir_up_d = 1'b0;
                    end else if (!up_eff && cur_y < Y_PAD && ny >= Y_PAD && on_paddle) begin
                        y_d      = Y_PAD[11:0];
                        dir_up_d = 1'b1;
                    end else if (ny >= Y_BOT) begin
                        y_d         = Y_BOT[11:0];
                        state_d     = ST_LOST;
                        ball_lost_d = 1'b1;
                        lost_cnt_d  = '0;
                    end else begin
                        y_d = ny[11:0];
                    end
                end
                ST_LOST: begin
                    if (lost_cnt_q == CNT_LAST) begin
                        state_d = ST_STICK;
                        x_d     = stick_x;
                        y_d     = Y_REST;
                    end else begin
                        lost_cnt_d = lost_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_STICK;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q      <= ST_STICK;
            x_q          <= X_RESET;
            y_q          <= Y_REST;
            dir_right_q  <= 1'b1;
            dir_up_q     <= 1'b1;
            vblnk_prev_q <= 1'b0;
            launch_req_q <= 1'b0;
            brick_req_q  <= 1'b0;
            ball_lost_q  <= 1'b0;
            lost_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            dir_right_q  <= dir_right_d;
            dir_up_q     <= dir_up_d;
            vblnk_prev_q <= vblnk_in;
            launch_req_q <= launch_req_d;
            brick_req_q  <= brick_req_d;
            ball_lost_q  <= ball_lost_d;
            lost_cnt_q   <= lost_cnt_d;
        end
    end

    assign x_pos     = x_q;
    assign y_pos     = y_q;
    assign ball_lost = ball_lost_q;
    assign state     = state_q;

endmodule

// File: tb/tb_ball_ctl.sv
// Bench for ball_ctl: frame-level ball model feeding an expected queue, checked every cycle,
// plus literal expectations at wall, paddle, brick, loss and reset points.
module tb_ball_ctl;

    localparam int EW = 27;
    localparam int LOST_FRAMES = 60;

    logic        pclk;
    logic        reset;
    logic        vblnk_in;
    logic        launch;
    logic [11:0] paddle_x;
    logic        brick_hit;
    logic [11:0] x_pos;
    logic [11:0] y_pos;
    logic        ball_lost;
    logic [1:0]  state;

    ball_ctl dut (
        .pclk      (pclk),
        .reset     (reset),
        .vblnk_in  (vblnk_in),
        .launch    (launch),
        .paddle_x  (paddle_x),
        .brick_hit (brick_hit),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .ball_lost (ball_lost),
        .state     (state)
    );

    // clock / reset
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    int n_chk = 0;
    int n_err = 0;
    logic check_en = 1'b0;

    // Expected entries: {state[1:0], ball_lost, x[11:0], y[11:0]}
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] cur_exp;

    // Frame-level model of the ball
    int m_x, m_y, m_state, m_vx, m_vy, m_lost_ticks;
    bit pend_launch, pend_brick;
    logic lost_at_tick, lost_after;

    function automatic int clamp_x(input int p);
        if (p < 10) return 10;
        if (p > 789) return 789;
        return p;
    endfunction

    function automatic logic [EW-1:0] pack_exp(input int st, input logic lost, input int x, input int y);
        return {2'(st), lost, 12'(x), 12'(y)};
    endfunction

    task automatic model_reset();
        m_x = 400; m_y = 549; m_state = 0; m_vx = 1; m_vy = -1; m_lost_ticks = 0;
        pend_launch = 0; pend_brick = 0;
        exp_q.push_back(pack_exp(m_state, 1'b0, m_x, m_y));
    endtask

    task automatic model_step();
        int nx, ny, dx;
        logic lost_now;
        lost_now = 1'b0;
        case (m_state)
            0: begin
                m_x = clamp_x(int'(paddle_x));
                m_y = 549;
                if (pend_launch) begin
                    m_state = 1; m_vx = 1; m_vy = -1;
                end
            end
            1: begin
                if (pend_brick) m_vy = -m_vy;
                nx = m_x + 4 * m_vx;
                ny = m_y + 4 * m_vy;
                dx = nx - int'(paddle_x);
                if (dx < 0) dx = -dx;
                if (nx <= 10) begin m_x = 10; m_vx = 1; end
                else if (nx >= 789) begin m_x = 789; m_vx = -1; end
                else m_x = nx;
                if (ny <= 10) begin m_y = 10; m_vy = 1; end
                else if (m_vy == 1 && m_y < 550 && ny >= 550 && dx <= 50) begin m_y = 550; m_vy = -1; end
                else if (ny >= 589) begin m_y = 589; m_state = 2; m_lost_ticks = 0; lost_now = 1'b1; end
                else m_y = ny;
            end
            default: begin
                m_lost_ticks++;
                if (m_lost_ticks == LOST_FRAMES) begin
                    m_state = 0;
                    m_x = clamp_x(int'(paddle_x));
                    m_y = 549;
                end
            end
        endcase
        pend_launch = 0;
        pend_brick = 0;
        exp_q.push_back(pack_exp(m_state, lost_now, m_x, m_y));
    endtask

    // scoreboard: every cycle the outputs must equal the latest expected entry
    always @(negedge pclk) begin
        if (check_en) begin
            if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
            n_chk++;
            if ({state, ball_lost, x_pos, y_pos} !== cur_exp) begin
                n_err++;
                $display("FAIL cycle_cmp t=%0t: got st=%0d lost=%0b x=%0d y=%0d, expected st=%0d lost=%0b x=%0d y=%0d",
                         $time, state, ball_lost, x_pos, y_pos,
                         cur_exp[26:25], cur_exp[24], cur_exp[23:12], cur_exp[11:0]);
            end
            cur_exp[24] = 1'b0;
        end
    end

    task automatic check_lit(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_pos(input string name, input int x, input int y, input int st);
        check_lit({name, "_x"}, int'(x_pos), x);
        check_lit({name, "_y"}, int'(y_pos), y);
        check_lit({name, "_state"}, int'(state), st);
    endtask

    // drivers
    task automatic tick();
        @(posedge pclk); #1; vblnk_in = 1'b1;
        @(posedge pclk); #1; model_step(); lost_at_tick = ball_lost;
        @(posedge pclk); #1; vblnk_in = 1'b0; lost_after = ball_lost;
        @(posedge pclk); #1;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_launch();
        @(posedge pclk); #1; launch = 1'b1;
        if (m_state == 0) pend_launch = 1;
        @(posedge pclk); #1; launch = 1'b0;
    endtask

    task automatic pulse_brick();
        @(posedge pclk); #1; brick_hit = 1'b1;
        if (m_state == 1) pend_brick = 1;
        @(posedge pclk); #1; brick_hit = 1'b0;
    endtask

    task automatic reset_dut();
        @(posedge pclk); #1; reset = 1'b1;
        @(posedge pclk); #1; reset = 1'b0; model_reset();
    endtask

    initial begin
        reset = 1'b1; vblnk_in = 1'b0; launch = 1'b0; brick_hit = 1'b0; paddle_x = 12'd300;
        @(posedge pclk); #1;
        reset = 1'b0;
        model_reset();
        check_en = 1'b1;
        check_pos("reset", 400, 549, 0);
        check_lit("reset_lost", int'(ball_lost), 0);

        // STICK follows the paddle, clamped at both edges
        tick();                       check_pos("stick300", 300, 549, 0);
        paddle_x = 12'd5;    tick();  check_pos("stick_clamp_lo", 10, 549, 0);
        paddle_x = 12'd900;  tick();  check_pos("stick_clamp_hi", 789, 549, 0);
        paddle_x = 12'd302;  tick();  check_pos("stick_nolaunch", 302, 549, 0);

        // launch; brick_hit while stuck has no effect
        pulse_brick();
        pulse_launch();
        tick();                       check_pos("launch", 302, 549, 1);
        tick();                       check_pos("first_step", 306, 545, 1);

        // right wall
        run_ticks(120);               check_pos("pre_right", 786, 65, 1);
        tick();                       check_pos("right_wall", 789, 61, 1);
        tick();                       check_pos("after_right", 785, 57, 1);

        // top wall
        run_ticks(11);                check_pos("pre_top", 741, 13, 1);
        tick();                       check_pos("top_wall", 737, 10, 1);
        tick();                       check_pos("after_top", 733, 14, 1);

        // paddle hit exactly at the half-width edge
        run_ticks(133);               check_pos("pre_paddle", 201, 546, 1);
        paddle_x = 12'd247;
        tick();                       check_pos("paddle_hit", 197, 550, 1);
        check_lit("paddle_no_lost", int'(lost_at_tick), 0);
        tick();                       check_pos("after_paddle", 193, 546, 1);

        // two brick pulses in one frame give a single reversal
        pulse_brick();
        pulse_brick();
        tick();                       check_pos("brick_rev", 189, 550, 1);

        // fall through to the bottom
        run_ticks(9);                 check_pos("pre_lost", 153, 586, 1);
        tick();                       check_pos("lost", 149, 589, 2);
        check_lit("lost_pulse", int'(lost_at_tick), 1);
        check_lit("lost_pulse_end", int'(lost_after), 0);

        // launch ignored in LOST; return to STICK after LOST_FRAMES ticks
        pulse_launch();
        paddle_x = 12'd300;
        run_ticks(59);                check_pos("lost_hold", 149, 589, 2);
        tick();                       check_pos("lost_return", 300, 549, 0);
        tick();                       check_pos("stick_after_lost", 300, 549, 0);

        // second flight: paddle one pixel too far misses
        paddle_x = 12'd302;
        pulse_launch();
        tick();
        run_ticks(269);               check_pos("pre_miss", 201, 546, 1);
        paddle_x = 12'd248;
        tick();                       check_pos("paddle_miss", 197, 550, 1);
        run_ticks(9);
        tick();                       check_pos("miss_lost", 157, 589, 2);
        check_lit("miss_lost_pulse", int'(lost_at_tick), 1);

        // reset mid-LOST
        run_ticks(5);
        reset_dut();                  check_pos("reset_lost", 400, 549, 0);

        // reset mid-MOVE
        paddle_x = 12'd500;
        tick();
        pulse_launch();
        tick();
        run_ticks(20);                check_pos("move3", 580, 469, 1);
        pulse_brick();
        reset_dut();                  check_pos("reset_move", 400, 549, 0);
        check_lit("reset_move_lost", int'(ball_lost), 0);

        // pending launch discarded by reset
        pulse_launch();
        reset_dut();
        tick();                       check_pos("launch_discard", 500, 549, 0);

        repeat (3) @(posedge pclk);
        #1;
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
